systolic_mm_core: RTL and testbench

SYSTOLIC_MM_CORE -- requirements
Module: systolic_mm_core

---
 rtl/systolic_mm_core.sv | 123 ++++++++++++
 tb/tb_systolic_mm_core.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/systolic_mm_core.sv
// rtl/systolic_mm_core.sv - 2x2 signed matrix multiply on an output-stationary systolic array
module systolic_mm_core #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic              load_sel_ab,
    input  logic [1:0]        load_index,
    input  logic [DATA_W-1:0] in_data,
    input  logic              output_en,
    input  logic [1:0]        output_sel,
    input  logic              output_hi,
    output logic [7:0]        out_data,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t                   state_q, state_d;
    logic signed [DATA_W-1:0] a_q [4];
    logic signed [DATA_W-1:0] b_q [4];
    logic signed [ACC_W-1:0]  c_q [4];
    logic signed [ACC_W-1:0]  c_d [4];
    logic [7:0]               mask_q, mask_d;
    logic [1:0]               step_q;
    logic                     done_q;
    logic [7:0]               out_q;

    logic [7:0]  load_bit;
    logic        load_ok;
    logic [15:0] c_word;
    logic [7:0]  out_byte;

    assign load_bit = 8'b1 << {load_sel_ab, load_index};
    assign load_ok  = load_en && (state_q != COMPUTE);
    assign c_word   = 16'(c_q[output_sel]);
    assign out_byte = output_hi ? c_word[15:8] : c_word[7:0];
    assign out_data = out_q;
    assign done     = done_q;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        case (state_q)
            IDLE: begin
                if (load_en) begin
                    mask_d = mask_q | load_bit;
                    if (mask_d == 8'hFF) begin
                        state_d = COMPUTE;
                        mask_d  = 8'h00;
                    end
                end
            end
            COMPUTE: begin
                if (step_q == 2'd2) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (load_en) begin
                    state_d = IDLE;
                    mask_d  = mask_q | load_bit;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Row i sees its A row delayed by i cycles; operand index k = step - i.
    always_comb begin
        logic [1:0]                 k;
        logic signed [2*DATA_W-1:0] prod;
        k    = 2'd0;
        prod = '0;
        for (int p = 0; p < 4; p++) begin
            c_d[p] = c_q[p];
            k      = step_q - {1'b0, p[1]};
            prod   = a_q[{p[1], k[0]}] * b_q[{k[0], p[0]}];
            if (state_q == COMPUTE && step_q >= {1'b0, p[1]} && k <= 2'd1) begin
                c_d[p] = c_q[p] + ACC_W'(prod);
            end
            if (state_q == IDLE && state_d == COMPUTE) begin
                c_d[p] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= 8'h00;
            step_q  <= 2'd0;
            done_q  <= 1'b0;
            out_q   <= 8'h00;
            for (int p = 0; p < 4; p++) begin
                a_q[p] <= '0;
                b_q[p] <= '0;
                c_q[p] <= '0;
            end
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            done_q  <= (state_d == DONE);
            step_q  <= (state_q == COMPUTE && state_d == COMPUTE) ? step_q + 2'd1 : 2'd0;
            for (int p = 0; p < 4; p++) begin
                c_q[p] <= c_d[p];
            end
            if (load_ok) begin
                if (load_sel_ab) begin
                    b_q[load_index] <= in_data;
                end else begin
                    a_q[load_index] <= in_data;
                end
            end
            if (output_en) begin
                out_q <= out_byte;
            end
        end
    end

endmodule

// File: tb/tb_systolic_mm_core.sv
// tb/tb_systolic_mm_core.sv - directed and randomized checks of systolic_mm_core against a plain matrix-product model
module tb_systolic_mm_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_en;
    logic       load_sel_ab;
    logic [1:0] load_index;
    logic [7:0] in_data;
    logic       output_en;
    logic [1:0] output_sel;
    logic       output_hi;
    logic [7:0] out_data;
    logic       done;

    int checks = 0;
    int errors = 0;
    int ma [4];
    int mb [4];
    int old_c [4];

    systolic_mm_core #(.DATA_W(8), .ACC_W(16)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_sel_ab(load_sel_ab),
        .load_index(load_index), .in_data(in_data), .output_en(output_en),
        .output_sel(output_sel), .output_hi(output_hi), .out_data(out_data), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rnd8();
        logic signed [7:0] t;
        t = 8'($urandom);
        return int'(t);
    endfunction

    function automatic int c_elem(input int p);
        int i;
        int j;
        i = p / 2;
        j = p % 2;
        return ma[2*i] * mb[j] + ma[2*i+1] * mb[2+j];
    endfunction

    function automatic logic [7:0] byte_of(input int v, input logic hi);
        logic [15:0] w;
        w = 16'(v);
        return hi ? w[15:8] : w[7:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic sel, input logic [1:0] idx, input int val);
        load_en = 1'b1; load_sel_ab = sel; load_index = idx; in_data = 8'(val);
        tick();
        load_en = 1'b0;
    endtask

    task automatic read(input logic [1:0] sel, input logic hi, output logic [7:0] v);
        output_en = 1'b1; output_sel = sel; output_hi = hi;
        tick();
        output_en = 1'b0;
        v = out_data;
    endtask

    // Loads all eight elements in a random order, then checks done latency.
    task automatic load_all(input string tag);
        int perm [8];
        for (int n = 0; n < 8; n++) perm[n] = n;
        for (int n = 7; n > 0; n--) begin
            int r;
            int t;
            r = int'($urandom_range(n, 0));
            t = perm[n]; perm[n] = perm[r]; perm[r] = t;
        end
        for (int n = 0; n < 8; n++) begin
            if (perm[n] < 4) load(1'b0, 2'(perm[n]), ma[perm[n]]);
            else             load(1'b1, 2'(perm[n] - 4), mb[perm[n] - 4]);
        end
        check({tag, "_done_c0"}, 16'(done), 16'd0);
        tick();
        check({tag, "_done_c1"}, 16'(done), 16'd0);
        tick();
        check({tag, "_done_c2"}, 16'(done), 16'd0);
        tick();
        check({tag, "_done_c3"}, 16'(done), 16'd1);
    endtask

    task automatic check_results(input string tag);
        logic [7:0] v;
        for (int p = 0; p < 4; p++) begin
            for (int h = 0; h < 2; h++) begin
                read(2'(p), h[0], v);
                check($sformatf("%s_c%0d_%s", tag, p, h ? "hi" : "lo"), 16'(v), 16'(byte_of(c_elem(p), h[0])));
            end
        end
    endtask

    initial begin
        logic [7:0] v;
        rst = 1'b1; load_en = 1'b0; load_sel_ab = 1'b0; load_index = 2'd0; in_data = 8'h00;
        output_en = 1'b0; output_sel = 2'd0; output_hi = 1'b0;
        tick();
        tick();
        check("reset_out", 16'(out_data), 16'h00);
        check("reset_done", 16'(done), 16'd0);
        rst = 1'b0;

        ma = '{1, 2, 3, 4}; mb = '{5, 6, 7, 8};
        load_all("basic");
        check_results("basic");
        read(2'd3, 1'b0, v);
        check("basic_c11_const", 16'(v), 16'h32);

        ma = '{-1, 2, 3, -4}; mb = '{5, -6, 7, 8};
        load_all("signed");
        check_results("signed");
        read(2'd3, 1'b0, v);
        check("signed_c11_lo", 16'(v), 16'hCE);
        read(2'd3, 1'b1, v);
        check("signed_c11_hi", 16'(v), 16'hFF);

        ma = '{-128, -128, -128, -128}; mb = '{-128, -128, -128, -128};
        load_all("wrap");
        check_results("wrap");
        read(2'd1, 1'b1, v);
        check("wrap_hi_const", 16'(v), 16'h80);

        for (int r = 0; r < 4; r++) begin
            for (int n = 0; n < 4; n++) begin
                ma[n] = rnd8();
                mb[n] = rnd8();
            end
            load_all($sformatf("rand%0d", r));
            check_results($sformatf("rand%0d", r));
        end

        ma = '{1, 2, 3, 4}; mb = '{5, 6, 7, 8};
        load(1'b0, 2'd0, 9);
        load(1'b0, 2'd0, 1);
        for (int n = 1; n < 4; n++) load(1'b0, 2'(n), ma[n]);
        for (int n = 0; n < 4; n++) load(1'b1, 2'(n), mb[n]);
        load(1'b0, 2'd0, 8'h55);
        check("ovr_done_c1", 16'(done), 16'd0);
        load(1'b1, 2'd3, 8'h55);
        check("ovr_done_c2", 16'(done), 16'd0);
        tick();
        check("ovr_done_c3", 16'(done), 16'd1);
        check_results("ovr");

        for (int n = 0; n < 4; n++) begin
            ma[n] = rnd8();
            mb[n] = rnd8();
        end
        for (int n = 0; n < 4; n++) load(1'b0, 2'(n), ma[n]);
        for (int n = 0; n < 4; n++) load(1'b1, 2'(n), mb[n]);
        tick();
        rst = 1'b1; output_en = 1'b1; output_sel = 2'd3; output_hi = 1'b0;
        load_en = 1'b1; in_data = 8'h77;
        tick();
        rst = 1'b0; output_en = 1'b0; load_en = 1'b0;
        check("midrst_done", 16'(done), 16'd0);
        check("midrst_out", 16'(out_data), 16'h00);
        read(2'd0, 1'b0, v);
        check("midrst_c_clear", 16'(v), 16'h00);
        load(1'b0, 2'd0, 1);
        load(1'b1, 2'd1, 1);
        load(1'b1, 2'd2, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            ma[n] = rnd8();
            mb[n] = rnd8();
        end
        for (int n = 0; n < 4; n++) load(1'b0, 2'(n), ma[n]);
        for (int n = 0; n < 3; n++) load(1'b1, 2'(n), mb[n]);
        for (int n = 0; n < 5; n++) tick();
        check("stale_mask_done", 16'(done), 16'd0);
        load(1'b1, 2'd3, mb[3]);
        tick();
        tick();
        tick();
        check("fresh_done", 16'(done), 16'd1);
        check_results("fresh");

        for (int p = 0; p < 4; p++) old_c[p] = c_elem(p);
        output_en = 1'b1; output_sel = 2'd3; output_hi = 1'b0;
        load_en = 1'b1; load_sel_ab = 1'b0; load_index = 2'd2; in_data = 8'h11;
        tick();
        output_en = 1'b0; load_en = 1'b0;
        check("reload_out", 16'(out_data), 16'(byte_of(old_c[3], 1'b0)));
        check("reload_done", 16'(done), 16'd0);
        for (int p = 0; p < 4; p++) begin
            read(2'(p), 1'b1, v);
            check($sformatf("retain_c%0d_hi", p), 16'(v), 16'(byte_of(old_c[p], 1'b1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
